// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation driver: opcode encodings, opcode width
// and the driver's state encoding.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] OP_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [ALU_OP_W-1:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } drv_state_e;

endpackage

// File: rtl/alu_op_driver_if.sv
// Request, ALU-side and response signals of the ALU operation driver.
// master = the driver itself, slave = the surrounding execute stage / ALU / consumer.
interface alu_op_driver_if
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic                req_valid;
  logic                req_ready;
  logic [ALU_OP_W-1:0] req_op;
  logic [DATA_W-1:0]   req_a;
  logic [DATA_W-1:0]   req_b;

  logic [ALU_OP_W-1:0] alu_op;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_out;
  logic                alu_zero;
  logic                alu_of;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_result;
  logic                rsp_zero;
  logic                rsp_of;
  logic                rsp_err;

  logic                busy;

  modport master (
    input  req_valid, req_op, req_a, req_b,
    input  alu_out, alu_zero, alu_of,
    input  rsp_ready,
    output req_ready, alu_op, alu_a, alu_b,
    output rsp_valid, rsp_result, rsp_zero, rsp_of, rsp_err, busy
  );

  modport slave (
    output req_valid, req_op, req_a, req_b,
    output alu_out, alu_zero, alu_of,
    output rsp_ready,
    input  req_ready, alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_result, rsp_zero, rsp_of, rsp_err, busy
  );

endinterface

// File: rtl/alu_op_driver.sv
// Initiator for a clocked ALU: accepts one op, holds registered operands for ALU_LAT
// edges, captures the result and holds it until taken. ALU_OP_DRIVER_STATS_EN adds op/overflow counters.
//
// state   | meaning
// IDLE    | ready for a request, ALU operands hold the last legal op
// WAIT    | operands on the ALU, counting down its result latency
// RESP    | captured result (or illegal-opcode error) offered to consumer
module alu_op_driver
  import alu_pkg::*;
#(
  parameter int                  DATA_W  = 32,
  parameter int                  ALU_LAT = 1,
  parameter logic [ALU_OP_W-1:0] MAX_OP  = 3'b101
) (
  input  logic            clk,
  input  logic            reset,
  alu_op_driver_if.master bus
`ifdef ALU_OP_DRIVER_STATS_EN
  ,
  output logic [15:0]     op_count,
  output logic [15:0]     of_count
`endif
);

  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT - 1);

  drv_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                zero_q, zero_d, of_q, of_d, err_q, err_d;
  logic                accept, legal, capture;

  assign accept  = bus.req_valid && (state_q == ST_IDLE);
  assign legal   = (bus.req_op <= MAX_OP);
  assign capture = (state_q == ST_WAIT) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    of_d    = of_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (legal) begin
            op_d    = bus.req_op;
            a_d     = bus.req_a;
            b_d     = bus.req_b;
            cnt_d   = LAT_LOAD;
            state_d = ST_WAIT;
          end else begin
            // Rejected op never touches the ALU; answer with an error right away.
            res_d   = '0;
            zero_d  = 1'b0;
            of_d    = 1'b0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (capture) begin
          res_d   = bus.alu_out;
          zero_d  = bus.alu_zero;
          of_d    = bus.alu_of;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      of_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      of_q    <= of_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.alu_op     = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_of     = of_q;
  assign bus.rsp_err    = err_q;

`ifdef ALU_OP_DRIVER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_count <= '0;
    end else if (accept && legal && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      of_count <= '0;
    end else if (capture && bus.alu_of && (of_count != 16'hFFFF)) begin
      of_count <= of_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver: two instances (ALU_LAT=1 and 4) share one request/response
// stream and are checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_alu_op_driver;
  import alu_pkg::*;

  localparam int DW   = 32;
  localparam int LAT0 = 1;
  localparam int LAT1 = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [2:0]    req_op;
  logic [DW-1:0] req_a, req_b;
  logic          rsp_ready;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  alu_op_driver_if #(.DATA_W(DW)) bus0 ();
  alu_op_driver_if #(.DATA_W(DW)) bus1 ();

  assign bus0.req_valid = req_valid;
  assign bus0.req_op    = req_op;
  assign bus0.req_a     = req_a;
  assign bus0.req_b     = req_b;
  assign bus0.rsp_ready = rsp_ready;
  assign bus1.req_valid = req_valid;
  assign bus1.req_op    = req_op;
  assign bus1.req_a     = req_a;
  assign bus1.req_b     = req_b;
  assign bus1.rsp_ready = rsp_ready;

  // ALU stub: A+B with Zero and signed-add overflow, {of, zero, sum}.
  function automatic logic [DW+1:0] alu_stub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] ext;
    ext = {a[DW-1], a} + {b[DW-1], b};
    return {ext[DW] ^ ext[DW-1], (ext[DW-1:0] == '0), ext[DW-1:0]};
  endfunction

  assign {bus0.alu_of, bus0.alu_zero, bus0.alu_out} = alu_stub(bus0.alu_a, bus0.alu_b);

  logic [DW+1:0] pipe1 [3];
  always_ff @(posedge clk) begin
    pipe1[0] <= alu_stub(bus1.alu_a, bus1.alu_b);
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign {bus1.alu_of, bus1.alu_zero, bus1.alu_out} = pipe1[2];

`ifdef ALU_OP_DRIVER_STATS_EN
  logic [15:0] opc [2];
  logic [15:0] ofc [2];
`endif

  alu_op_driver #(.DATA_W(DW), .ALU_LAT(LAT0), .MAX_OP(3'b101)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
`ifdef ALU_OP_DRIVER_STATS_EN
    , .op_count(opc[0]), .of_count(ofc[0])
`endif
  );

  alu_op_driver #(.DATA_W(DW), .ALU_LAT(LAT1), .MAX_OP(3'b101)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
`ifdef ALU_OP_DRIVER_STATS_EN
    , .op_count(opc[1]), .of_count(ofc[1])
`endif
  );

  logic          o_ready [2], o_busy [2], o_valid [2], o_zero [2], o_of [2], o_err [2];
  logic [2:0]    o_op  [2];
  logic [DW-1:0] o_a [2], o_b [2], o_res [2];

  assign o_ready[0] = bus0.req_ready;   assign o_ready[1] = bus1.req_ready;
  assign o_busy[0]  = bus0.busy;        assign o_busy[1]  = bus1.busy;
  assign o_valid[0] = bus0.rsp_valid;   assign o_valid[1] = bus1.rsp_valid;
  assign o_zero[0]  = bus0.rsp_zero;    assign o_zero[1]  = bus1.rsp_zero;
  assign o_of[0]    = bus0.rsp_of;      assign o_of[1]    = bus1.rsp_of;
  assign o_err[0]   = bus0.rsp_err;     assign o_err[1]   = bus1.rsp_err;
  assign o_op[0]    = bus0.alu_op;      assign o_op[1]    = bus1.alu_op;
  assign o_a[0]     = bus0.alu_a;       assign o_a[1]     = bus1.alu_a;
  assign o_b[0]     = bus0.alu_b;       assign o_b[1]     = bus1.alu_b;
  assign o_res[0]   = bus0.rsp_result;  assign o_res[1]   = bus1.rsp_result;

  task automatic chk32(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[lat%0d] cyc=%0d got=%h want=%h", name, (k == 0) ? LAT0 : LAT1, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input int k, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[lat%0d] cyc=%0d got=%b want=%b", name, (k == 0) ? LAT0 : LAT1, cyc, act, exp);
    end
  endtask

  // Transaction model: one outstanding op per instance, response visible from a
  // known cycle, previous response data retained once consumed.
  bit            m_pend [2];
  int            m_valid_at [2];
  logic [2:0]    m_op [2];
  logic [DW-1:0] m_a [2], m_b [2];
  logic [DW-1:0] n_res [2], l_res [2];
  logic          n_zero [2], n_of [2], n_err [2], l_zero [2], l_of [2], l_err [2];
  int            m_opc [2], m_ofc [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int lat;
      bit shown;
      lat = (k == 0) ? LAT0 : LAT1;
      if (reset !== 1'b1) begin
        m_pend[k] = 0; m_valid_at[k] = 0; m_op[k] = '0; m_a[k] = '0; m_b[k] = '0;
        l_res[k] = '0; l_zero[k] = 0; l_of[k] = 0; l_err[k] = 0; m_opc[k] = 0; m_ofc[k] = 0;
      end
      shown = m_pend[k] && (cyc >= m_valid_at[k]);
      chk1("req_ready", k, o_ready[k], !m_pend[k]);
      chk1("busy", k, o_busy[k], m_pend[k]);
      chk1("rsp_valid", k, o_valid[k], shown);
      chk32("alu_op", k, 32'(o_op[k]), 32'(m_op[k]));
      chk32("alu_a", k, o_a[k], m_a[k]);
      chk32("alu_b", k, o_b[k], m_b[k]);
      chk32("rsp_result", k, o_res[k], shown ? n_res[k] : l_res[k]);
      chk1("rsp_zero", k, o_zero[k], shown ? n_zero[k] : l_zero[k]);
      chk1("rsp_of", k, o_of[k], shown ? n_of[k] : l_of[k]);
      chk1("rsp_err", k, o_err[k], shown ? n_err[k] : l_err[k]);
`ifdef ALU_OP_DRIVER_STATS_EN
      chk32("op_count", k, 32'(opc[k]), 32'(m_opc[k]));
      chk32("of_count", k, 32'(ofc[k]), 32'(m_ofc[k] + ((shown && n_of[k] && !n_err[k]) ? 1 : 0)));
`endif
      if (reset === 1'b1) begin
        if (!m_pend[k]) begin
          if (req_valid === 1'b1) begin
            m_pend[k] = 1;
            if (req_op <= 3'd5) begin
              m_op[k] = req_op; m_a[k] = req_a; m_b[k] = req_b;
              n_res[k]  = req_a + req_b;
              n_zero[k] = (n_res[k] == '0);
              n_of[k]   = (req_a[DW-1] == req_b[DW-1]) && (n_res[k][DW-1] != req_a[DW-1]);
              n_err[k]  = 0;
              m_valid_at[k] = cyc + lat + 1;
              m_opc[k]++;
            end else begin
              n_res[k] = '0; n_zero[k] = 0; n_of[k] = 0; n_err[k] = 1;
              m_valid_at[k] = cyc + 1;
            end
          end
        end else if (shown && rsp_ready === 1'b1) begin
          m_pend[k] = 0;
          l_res[k] = n_res[k]; l_zero[k] = n_zero[k]; l_of[k] = n_of[k]; l_err[k] = n_err[k];
          if (n_of[k] && !n_err[k]) m_ofc[k]++;
        end
      end
    end
    cyc++;
  end

  int            first [2];
  logic [DW-1:0] got_res [2];
  logic          got_zero [2], got_of [2], got_err [2];

  task automatic wait_both_ready();
    bit ok;
    ok = 0;
    for (int j = 0; j < 60 && !ok; j++) begin
      @(negedge clk);
      ok = (o_ready[0] === 1'b1) && (o_ready[1] === 1'b1);
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL ready_timeout got=busy want=idle within 60 cycles");
    end
  endtask

  // Issue one request to both instances; rsp_ready stays low until both responses
  // have been visible for 'hold' cycles.
  task automatic run_op(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
    int seen;
    bit done;
    first[0] = 0; first[1] = 0; seen = 0; done = 0;
    wait_both_ready();
    @(posedge clk); #1;
    req_valid = 1; req_op = op; req_a = a; req_b = b; rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 0; req_op = 3'($urandom); req_a = $urandom; req_b = $urandom;
    for (int j = 1; j <= 60 && !done; j++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (o_valid[k] === 1'b1 && first[k] == 0) begin
          first[k] = j; got_res[k] = o_res[k]; got_zero[k] = o_zero[k];
          got_of[k] = o_of[k]; got_err[k] = o_err[k];
        end
      end
      if (first[0] != 0 && first[1] != 0) begin
        seen++;
        if (rsp_ready && o_ready[0] === 1'b1 && o_ready[1] === 1'b1) done = 1;
      end
      @(posedge clk); #1;
      if (seen >= hold) rsp_ready = 1;
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout got=no_response want=response within 60 cycles");
    end
  endtask

  function automatic logic [DW-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
`ifdef ALU_OP_DRIVER_STATS_EN
    logic [15:0] opc_base, ofc_base;
`endif
    reset = 0; req_valid = 0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk1("rst_req_ready", 0, o_ready[0], 1'b1);
    chk32("rst_rsp_result", 1, o_res[1], 32'h0);

    // Basic op; latencies measured from the accept edge.
    run_op(3'b000, 32'hFF00_3000, 32'hFFFF_2900, 0);
    for (int k = 0; k < 2; k++) begin
      chk32("add_result", k, got_res[k], 32'hFEFF_5900);
      chk1("add_zero", k, got_zero[k], 1'b0);
      chk1("add_of", k, got_of[k], 1'b0);
      chk1("add_err", k, got_err[k], 1'b0);
    end
    chk32("latency", 0, 32'(first[0]), 32'd2);
    chk32("latency", 1, 32'(first[1]), 32'd5);

    // Response backpressure.
    run_op(3'b000, 32'hFF00_3000, 32'hFFFF_2900, 5);
    chk32("bp_result", 1, got_res[1], 32'hFEFF_5900);

`ifdef ALU_OP_DRIVER_STATS_EN
    opc_base = opc[0]; ofc_base = ofc[0];
`endif
    run_op(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    for (int k = 0; k < 2; k++) begin
      chk32("ovf_result", k, got_res[k], 32'h8000_0000);
      chk1("ovf_of", k, got_of[k], 1'b1);
    end
    run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    for (int k = 0; k < 2; k++) begin
      chk32("zero_result", k, got_res[k], 32'h0);
      chk1("zero_zero", k, got_zero[k], 1'b1);
      chk1("zero_of", k, got_of[k], 1'b0);
    end
`ifdef ALU_OP_DRIVER_STATS_EN
    chk32("stat_op_count", 0, 32'(opc[0] - opc_base), 32'd2);
    chk32("stat_of_count", 0, 32'(ofc[0] - ofc_base), 32'd1);
`endif

    // Illegal opcode: immediate error, ALU operands untouched.
    run_op(3'b110, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    for (int k = 0; k < 2; k++) begin
      chk32("illegal_latency", k, 32'(first[k]), 32'd1);
      chk1("illegal_err", k, got_err[k], 1'b1);
      chk32("illegal_result", k, got_res[k], 32'h0);
      chk32("illegal_alu_a", k, o_a[k], 32'hFFFF_FFFF);
      chk32("illegal_alu_b", k, o_b[k], 32'h0000_0001);
    end

    // Async reset with lat1 in RESP and lat4 in WAIT.
    wait_both_ready();
    @(posedge clk); #1;
    req_valid = 1; req_op = 3'b010; req_a = 32'h1234_5678; req_b = 32'h1111_1111; rsp_ready = 1;
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #3 reset = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk1("arst_req_ready", k, o_ready[k], 1'b1);
      chk1("arst_busy", k, o_busy[k], 1'b0);
      chk1("arst_rsp_valid", k, o_valid[k], 1'b0);
      chk32("arst_alu_a", k, o_a[k], 32'h0);
      chk32("arst_rsp_result", k, o_res[k], 32'h0);
    end
    @(posedge clk); #1 reset = 1;
    repeat (8) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk1("arst_no_rsp", k, o_valid[k], 1'b0);
    end

    // Random traffic, including request changes while busy.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 2) != 0);
      req_op    = 3'($urandom_range(0, 7));
      req_a     = pick_operand();
      req_b     = pick_operand();
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid = 0; rsp_ready = 1;
    wait_both_ready();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_op_driver.md
Name: alu_op_driver

Overview:
- Initiator side of the ALU operation interface: ALU_OP/A/B out, ALUOut/Zero/OF back.
- Accepts one operation request over a valid/ready handshake and drives the clocked ALU with registered operands.
- Waits the ALU's fixed result latency, captures ALUOut/Zero/OF, and holds the response until the consumer accepts it.
- Sits between the execute-stage control and the ALU; replaces ad-hoc timed stimulus with a protocol-correct requester.

Parameters:
- DATA_W, 32, operand/result width.
- ALU_LAT, 1, clock edges from operands valid at ALU inputs to ALUOut/Zero/OF valid; legal range 1..15.
- MAX_OP, 3'b101, highest legal opcode; opcodes above it are rejected.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept a request.
- req_op  in  3  ALU opcode.
- req_a  in  DATA_W  operand A.
- req_b  in  DATA_W  operand B.
- alu_op  out  3  to ALU ALU_OP.
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- alu_out  in  DATA_W  from ALU ALUOut.
- alu_zero  in  1  from ALU Zero.
- alu_of  in  1  from ALU OF.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  DATA_W  captured ALUOut.
- rsp_zero  out  1  captured Zero.
- rsp_of  out  1  captured OF.
- rsp_err  out  1  request had an illegal opcode.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, async) values:
  - state = IDLE; req_ready = 1; busy = 0.
  - alu_op = 3'b000; alu_a = 0; alu_b = 0.
  - rsp_valid = 0; rsp_result = 0; rsp_zero = 0; rsp_of = 0; rsp_err = 0.
  - Wait counter = 0.
- States: IDLE, WAIT, RESP. req_ready = (state==IDLE), combinational from state only.
- IDLE, on req_valid&&req_ready with req_op<=MAX_OP:
  - Register alu_op/alu_a/alu_b from the request.
  - Load counter with ALU_LAT-1; go to WAIT.
- IDLE, on req_valid&&req_ready with req_op>MAX_OP:
  - alu_* unchanged.
  - Go to RESP with rsp_err=1, rsp_result=0, rsp_zero=0, rsp_of=0.
- WAIT:
  - alu_* held stable for the whole state.
  - Counter>0: decrement.
  - Counter==0: capture alu_out/alu_zero/alu_of into rsp_*, set rsp_err=0, go to RESP.
- RESP:
  - rsp_valid=1; rsp_* held stable while rsp_ready=0.
  - On rsp_ready: go to IDLE, rsp_valid=0 next cycle. rsp_* data keeps its last value.
- Latency, request accepted at edge N:
  - ALU sees operands from cycle N+1.
  - Capture at edge N+ALU_LAT; rsp_valid high from cycle N+ALU_LAT+1.
  - Illegal opcode: rsp_valid high from cycle N+1.
- Throughput: no request is accepted in WAIT or RESP; back-to-back ops take ALU_LAT+2 cycles each with rsp_ready tied high.
- rsp_ready in IDLE or WAIT is ignored.
- req_* changes while not ready are ignored; nothing is latched outside the accept edge.
- Reset mid-operation (WAIT or RESP): all outputs return to reset values and the pending operation is dropped with no response.
- No arithmetic is done in this block; widths pass through unmodified.

Optional Feature:
- Macro: ALU_OP_DRIVER_STATS_EN.
- Defined: adds outputs op_count[15:0] and of_count[15:0], both reset to 0.
  - op_count increments on each accepted legal request.
  - of_count increments on each capture with alu_of=1.
  - Both saturate at 16'hFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams for 3'b000..3'b101.
  - ALU_OP_W=3.
  - State encoding typedef for IDLE/WAIT/RESP.
- No sub-module; the optional counters are two small always blocks inside the driver.

Test Plan:
- Bench ALU stub: registered A+B, Zero = (sum==0), OF = signed add overflow.
- Legal op, ALU_LAT=1: req op=3'b000, A=32'hFF00_3000, B=32'hFFFF_2900 at edge N -> alu_a/alu_b visible at N+1; rsp_valid at N+2 with result=32'hFEFF_5900, zero=0, of=0, err=0.
- Response backpressure: same request with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_* stable for 5 cycles, req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
- Overflow and zero: A=32'h7FFF_FFFF, B=1 -> of=1, result=32'h8000_0000. A=32'hFFFF_FFFF, B=1 -> zero=1, result=0. With STATS_EN, of_count=1 and op_count=2 after both.
- Illegal opcode: req op=3'b110 -> rsp_valid next cycle, err=1, result=0; alu_* unchanged from the previous operation.
- Latency parameter: ALU_LAT=4, accept at edge N -> rsp_valid first high at N+5; alu_* stable from N+1 through the capture.
- Async reset: reset=0 mid-WAIT, between edges -> outputs reach reset values immediately; after release no response appears and req_ready=1.
